blake2_io_ctrl: RTL

Parametrised host-side input controller for the BLAKE2 core. Captures the keyed-hash configuration (kk, nn, ll) from a byte stream, slices message data into fixed-size blocks of W-byte beats with per-beat index and first/last block flags, and zero-pads a short final block autonomously while back-pressuring the host. Sits between the chip I/O pins and the compression core; it supersedes the fixed 1-byte/64-byte interface, and BB=128 serves BLAKE2b.

---
 rtl/blake2_io_ctrl_pkg.sv | 29 ++
 rtl/blake2_io_ctrl_if.sv | 12 +
 rtl/blake2_io_ctrl_cfg_capture.sv | 53 +++++
 rtl/blake2_io_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/blake2_io_ctrl_pkg.sv
// Shared definitions for the BLAKE2 host input controller: command encoding,
// FSM states and configuration byte slots.
package blake2_io_pkg;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_LAST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG,
    ST_DATA,
    ST_PAD
  } state_e;

  // Configuration byte slots: kk, nn, then ll bytes MSB-first.
  localparam int CFG_KK     = 0;
  localparam int CFG_NN     = 1;
  localparam int CFG_LL_MIN = 2;

  // Counter width able to hold the saturation slot one past ll's last byte.
  function automatic int cfg_cnt_w(input int ll_w);
    return $clog2(CFG_LL_MIN + ll_w / 8 + 1);
  endfunction

endpackage

// File: rtl/blake2_io_ctrl_if.sv
// Host-side beat handshake of the BLAKE2 input controller.
interface blake2_io_ctrl_if #(
  parameter int W = 1
);
  logic           valid_i;
  logic [1:0]     cmd_i;
  logic [8*W-1:0] data_i;
  logic           ready_o;

  modport master (output valid_i, cmd_i, data_i, input ready_o);
  modport slave  (input valid_i, cmd_i, data_i, output ready_o);
endinterface

// File: rtl/blake2_io_ctrl_cfg_capture.sv
// Configuration byte capture: saturating slot counter feeding kk, nn and an
// MSB-first ll shift register. ovf output exists only with IO_PROTO_ERR_EN.
module io_cfg_capture
  import blake2_io_pkg::*;
#(
  parameter int LL_W = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            restart,
  input  logic            capture,
  input  logic [7:0]      cfg_byte,
  output logic [7:0]      kk,
  output logic [7:0]      nn,
  output logic [LL_W-1:0] ll
`ifdef IO_PROTO_ERR_EN
  ,
  output logic            ovf
`endif
);

  localparam int CNT_W = cfg_cnt_w(LL_W);
  localparam logic [CNT_W-1:0] SLOT_KK  = CNT_W'(CFG_KK);
  localparam logic [CNT_W-1:0] SLOT_NN  = CNT_W'(CFG_NN);
  localparam logic [CNT_W-1:0] SLOT_SAT = CNT_W'(CFG_LL_MIN + LL_W / 8);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] slot;

  // A CONF arriving outside CFG is always byte 0 of a fresh sequence.
  assign slot = restart ? '0 : cnt_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
      kk    <= '0;
      nn    <= '0;
      ll    <= '0;
    end else if (capture) begin
      if (slot == SLOT_KK)       kk <= cfg_byte;
      else if (slot == SLOT_NN)  nn <= cfg_byte;
      else if (slot != SLOT_SAT) ll <= {ll[LL_W-9:0], cfg_byte};
      cnt_q <= (slot == SLOT_SAT) ? SLOT_SAT : slot + 1'b1;
    end
  end

`ifdef IO_PROTO_ERR_EN
  assign ovf = capture && (slot == SLOT_SAT);
`endif

endmodule

// File: rtl/blake2_io_ctrl.sv
// Host-side input controller for the BLAKE2 core: config capture, block
// slicing into W-byte beats and autonomous zero padding of short final blocks.
// Optional sticky protocol error flag: define IO_PROTO_ERR_EN.
module blake2_io_ctrl
  import blake2_io_pkg::*;
#(
  parameter  int BB    = 64,
  parameter  int W     = 1,
  parameter  int LL_W  = 64,
  localparam int IDX_W = $clog2(BB / W)
) (
  input  logic             clk,
  input  logic             nreset,
  blake2_io_ctrl_if.slave  host,
  output logic [7:0]       kk_o,
  output logic [7:0]       nn_o,
  output logic [LL_W-1:0]  ll_o,
  output logic             data_v_o,
  output logic [8*W-1:0]   data_o,
  output logic [IDX_W-1:0] data_idx_o,
  output logic             block_first_o,
  output logic             block_last_o,
  output logic             block_end_o,
  output logic             pad_o,
  output logic             err_o
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BB / W - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;     // index of the next beat to emit
  logic             first_q, first_d;

  logic             acc;
  cmd_e             cmd;
  logic             last_slot;

  logic             emit;
  logic [8*W-1:0]   beat_data;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_first;
  logic             beat_last;
  logic             beat_end;
  logic             beat_pad;
  logic             cfg_restart;
  logic             cfg_capture;

  assign host.ready_o = (state_q != ST_PAD);
  assign acc          = host.valid_i && host.ready_o;
  assign cmd          = cmd_e'(host.cmd_i);
  assign last_slot    = (idx_q == IDX_MAX);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    first_d     = first_q;
    emit        = 1'b0;
    beat_data   = host.data_i;
    beat_idx    = idx_q;
    beat_first  = first_q;
    beat_last   = 1'b0;
    beat_end    = 1'b0;
    beat_pad    = 1'b0;
    cfg_restart = 1'b0;
    cfg_capture = 1'b0;

    if (acc && cmd == CMD_START) begin
      // START restarts the message from any accepting state, abandoning
      // whatever partial block was in flight.
      emit       = 1'b1;
      beat_idx   = '0;
      beat_first = 1'b1;
      first_d    = 1'b1;
      idx_d      = IDX_W'(1);
      state_d    = ST_DATA;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (acc && cmd == CMD_CONF) begin
            cfg_capture = 1'b1;
            cfg_restart = 1'b1;
            state_d     = ST_CFG;
          end
        end
        ST_CFG: begin
          if (acc) begin
            if (cmd == CMD_CONF) cfg_capture = 1'b1;
            else                 state_d     = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (acc) begin
            unique case (cmd)
              CMD_CONF: begin
                cfg_capture = 1'b1;
                cfg_restart = 1'b1;
                state_d     = ST_CFG;
              end
              CMD_DATA: begin
                emit     = 1'b1;
                beat_end = last_slot;
                idx_d    = last_slot ? '0 : idx_q + 1'b1;
                if (last_slot) first_d = 1'b0;
              end
              CMD_LAST: begin
                emit      = 1'b1;
                beat_last = 1'b1;
                beat_end  = last_slot;
                idx_d     = last_slot ? '0 : idx_q + 1'b1;
                state_d   = last_slot ? ST_IDLE : ST_PAD;
              end
              default: ;
            endcase
          end
        end
        ST_PAD: begin
          emit      = 1'b1;
          beat_data = '0;
          beat_pad  = 1'b1;
          beat_last = 1'b1;
          beat_end  = last_slot;
          idx_d     = last_slot ? '0 : idx_q + 1'b1;
          if (last_slot) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Beat fields hold between beats; only the strobes fall back to zero.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      data_v_o      <= 1'b0;
      data_o        <= '0;
      data_idx_o    <= '0;
      block_first_o <= 1'b0;
      block_last_o  <= 1'b0;
      block_end_o   <= 1'b0;
      pad_o         <= 1'b0;
    end else begin
      data_v_o    <= emit;
      block_end_o <= beat_end;
      pad_o       <= beat_pad;
      if (emit) begin
        data_o        <= beat_data;
        data_idx_o    <= beat_idx;
        block_first_o <= beat_first;
        block_last_o  <= beat_last;
      end
    end
  end

`ifdef IO_PROTO_ERR_EN
  logic cfg_ovf;
  logic err_set;
  logic err_q;

  io_cfg_capture #(.LL_W(LL_W)) u_cfg (
    .clk      (clk),
    .nreset   (nreset),
    .restart  (cfg_restart),
    .capture  (cfg_capture),
    .cfg_byte (host.data_i[7:0]),
    .kk       (kk_o),
    .nn       (nn_o),
    .ll       (ll_o),
    .ovf      (cfg_ovf)
  );

  assign err_set = acc && (
      (state_q == ST_IDLE && (cmd == CMD_DATA || cmd == CMD_LAST)) ||
      (state_q == ST_CFG  && (cmd == CMD_DATA || cmd == CMD_LAST)) ||
      (state_q == ST_DATA && cmd == CMD_CONF)                      ||
      (state_q == ST_DATA && cmd == CMD_START && idx_q != '0)      ||
      cfg_ovf);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)      err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  io_cfg_capture #(.LL_W(LL_W)) u_cfg (
    .clk      (clk),
    .nreset   (nreset),
    .restart  (cfg_restart),
    .capture  (cfg_capture),
    .cfg_byte (host.data_i[7:0]),
    .kk       (kk_o),
    .nn       (nn_o),
    .ll       (ll_o)
  );

  assign err_o = 1'b0;
`endif

endmodule
